// File: rtl/cmult_ctrl_pkg.sv
// Shared definitions for the complex-multiplier flow controller:
// FSM state encoding and the occupancy-width helper.
package cmult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    // Bits needed to hold values 0..value-1; callers pass LATENCY+1 (always >= 3).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((longint'(1) << i) < longint'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cmult_valid_tracker.sv
// Valid-bit shadow of the datapath delay lines plus a running count of
// valid samples in flight.
module cmult_valid_tracker #(
    parameter int LATENCY = 4,
    parameter int OCC_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             accept,
    input  logic             deliver,
    output logic             valid_out,
    output logic [OCC_W-1:0] occupancy
);

    logic [LATENCY-1:0] vpipe;

    // Moves in lock-step with the datapath: only on shift_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else if (shift_en) begin
            vpipe <= {vpipe[LATENCY-2:0], accept};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(accept) - OCC_W'(deliver);
        end
    end

    assign valid_out = vpipe[LATENCY-1];

    always @(posedge clk) begin
        if (rst_n) begin
            assert (occupancy <= OCC_W'(LATENCY));
        end
    end

endmodule

// File: rtl/cmult_pipe_ctrl.sv
// Flow controller for the complex multiplier pipeline: shift enable, handshakes,
// start/run/flush sequencing. Define CMULT_PIPE_CTRL_STATS_EN to build the in/out counters.
module cmult_pipe_ctrl
    import cmult_ctrl_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic                            i_flush,
    input  logic                            i_valid_in,
    output logic                            o_ready_in,
    output logic                            o_shift_en,
    output logic                            o_valid_out,
    input  logic                            i_ready_out,
    output logic                            o_busy,
    output logic                            o_flush_done,
    output logic [clog2(LATENCY+1)-1:0]     o_occupancy,
    output logic [CNT_W-1:0]                o_in_count,
    output logic [CNT_W-1:0]                o_out_count
);

    localparam int OCC_W = clog2(LATENCY + 1);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic        accept;
    logic        deliver;

    assign accept  = i_valid_in & o_ready_in;
    assign deliver = o_valid_out & i_ready_out;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Start wins over flush in IDLE simply because IDLE never looks at flush.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (i_start) state_next = ST_RUN;
            ST_RUN:   if (i_flush) state_next = ST_FLUSH;
            ST_FLUSH: if (o_occupancy == '0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // A full pipe stalls only while its head result is still unread.
    always_comb begin
        o_shift_en   = 1'b0;
        o_ready_in   = 1'b0;
        o_busy       = (state != ST_IDLE);
        o_flush_done = (state == ST_DONE);
        case (state)
            ST_RUN: begin
                o_shift_en = !o_valid_out | i_ready_out;
                o_ready_in = o_shift_en;
            end
            ST_FLUSH: begin
                o_shift_en = !o_valid_out | i_ready_out;
            end
            default: ;
        endcase
    end

    cmult_valid_tracker #(
        .LATENCY (LATENCY),
        .OCC_W   (OCC_W)
    ) u_tracker (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .shift_en  (o_shift_en),
        .accept    (accept),
        .deliver   (deliver),
        .valid_out (o_valid_out),
        .occupancy (o_occupancy)
    );

`ifdef CMULT_PIPE_CTRL_STATS_EN
    logic [CNT_W-1:0] in_count;
    logic [CNT_W-1:0] out_count;

    // Free-running, wrap naturally; cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_count  <= '0;
            out_count <= '0;
        end else begin
            if (accept)  in_count  <= in_count + 1'b1;
            if (deliver) out_count <= out_count + 1'b1;
        end
    end

    assign o_in_count  = in_count;
    assign o_out_count = out_count;
`else
    assign o_in_count  = '0;
    assign o_out_count = '0;
`endif

endmodule
